// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per
//   clock, LSB first, carrying the borrow in a flop between bit slices.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset (priority over start)
//   start      : request a subtraction; only looked at while idle
//   a, b       : minuend / subtrahend, captured on the accepting edge
//   busy       : high while bit slices are being processed
//   done       : one-cycle pulse, diff/borrow_out freshly valid
//   diff       : (a - b) mod 2^WIDTH, held until the next completion
//   borrow_out : final borrow, 1 iff a < b (unsigned), held likewise
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Full-subtractor difference bit for one slice.
  function automatic logic sub_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  // Full-subtractor borrow: borrow when x<y, or when x==y and a borrow came in.
  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sa_r, sa_s;
  logic [WIDTH-1:0] sb_r, sb_s;
  logic [WIDTH-1:0] sr_r, sr_s;
  logic             br_r, br_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] diff_r, diff_s;
  logic             bout_r, bout_s;
  logic             d_s;
  logic             nb_s;

  // Next-state and next-output logic for the controller and datapath.
  always_comb begin
    state_s = state_r;
    sa_s    = sa_r;
    sb_s    = sb_r;
    sr_s    = sr_r;
    br_s    = br_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    done_s  = done_r;
    diff_s  = diff_r;
    bout_s  = bout_r;
    d_s     = sub_diff(sa_r[0], sb_r[0], br_r);
    nb_s    = sub_borrow(sa_r[0], sb_r[0], br_r);

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          sa_s    = a;
          sb_s    = b;
          br_s    = 1'b0;
          cnt_s   = '0;
          busy_s  = 1'b1;
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sa_s  = {1'b0, sa_r[WIDTH-1:1]};
        sb_s  = {1'b0, sb_r[WIDTH-1:1]};
        sr_s  = {d_s, sr_r[WIDTH-1:1]};
        br_s  = nb_s;
        cnt_s = cnt_r + CW'(1);
        if (cnt_r == LAST) begin
          // Last slice: publish the assembled result and final borrow.
          diff_s  = {d_s, sr_r[WIDTH-1:1]};
          bout_s  = nb_s;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        done_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sa_r    <= '0;
      sb_r    <= '0;
      sr_r    <= '0;
      br_r    <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      diff_r  <= '0;
      bout_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sa_r    <= sa_s;
      sb_r    <= sb_s;
      sr_r    <= sr_s;
      br_r    <= br_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      diff_r  <= diff_s;
      bout_r  <= bout_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = bout_r;

endmodule
